// File: rtl/rr_mux_reg_pkg.sv
// rr_mux_pkg: shared constants and helpers for the round-robin registered mux
package rr_mux_pkg;
  localparam int DEF_WIDTH = 32;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_mux_reg_if.sv
// rr_mux_reg_if: producer-side and consumer-side handshake bundle for rr_mux_reg
interface rr_mux_reg_if import rr_mux_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH = 4,
  parameter int CHW = clog2_min1(NCH)
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0] in_valid;
  logic [NCH-1:0] in_ready;
  logic [WIDTH-1:0] out_data;
  logic out_valid;
  logic [CHW-1:0] out_ch;
  logic out_ready;
  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid, out_ch);
  modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid, out_ch);
endinterface

// File: rtl/rr_mux_reg_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from ptr upward with wrap
module rr_arbiter import rr_mux_pkg::*; #(
  parameter int NCH = 4,
  parameter int CHW = clog2_min1(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [CHW-1:0] i_ptr,
  output logic [NCH-1:0] o_grant,
  output logic [CHW-1:0] o_winner,
  output logic           o_any
);
  localparam logic [CHW:0] NCHV = (CHW+1)'(NCH);
  logic [NCH-1:0] w_rot, w_pick;
  logic [CHW-1:0] w_off;
  logic [CHW:0] w_sum;
  // rotate requests so ptr sits at bit 0, take the lowest set bit, rotate the pick back
  always_comb begin
    w_rot = NCH'({i_req, i_req} >> i_ptr);
    w_pick = '0;
    w_off = '0;
    for (int j = NCH-1; j >= 0; j--)
      if (w_rot[j]) begin
        w_pick = NCH'(1) << j;
        w_off = CHW'(j);
      end
    o_grant = NCH'(({w_pick, w_pick} << i_ptr) >> NCH);
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    o_winner = (w_sum >= NCHV) ? CHW'(w_sum - NCHV) : w_sum[CHW-1:0];
    o_any = |i_req;
  end
endmodule

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: NCH-way valid/ready mux with round-robin arbitration and a one-entry output register
module rr_mux_reg import rr_mux_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH = 4,
  parameter int CHW = clog2_min1(NCH)
) (
  input logic clk,
  input logic rst,
  rr_mux_reg_if.slave bus
);
  logic [CHW-1:0] r_ptr, r_ch, w_win;
  logic [WIDTH-1:0] r_data;
  logic r_valid, w_load, w_any;
  logic [NCH-1:0] w_grant;
  rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
    .i_req(bus.in_valid),
    .i_ptr(r_ptr),
    .o_grant(w_grant),
    .o_winner(w_win),
    .o_any(w_any)
  );
  assign w_load = !rst && w_any && (!r_valid || bus.out_ready);
  assign bus.in_ready = w_load ? w_grant : '0;
  assign bus.out_data = r_data;
  assign bus.out_valid = r_valid;
  assign bus.out_ch = r_ch;
  // output register and pointer; the pointer moves just past each winner and only on load
  always_ff @(posedge clk)
    if (rst) begin
      r_valid <= 1'b0;
      r_data <= '0;
      r_ch <= '0;
      r_ptr <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data <= bus.in_data[w_win*WIDTH +: WIDTH];
      r_ch <= w_win;
      r_ptr <= (w_win == CHW'(NCH-1)) ? '0 : w_win + CHW'(1);
    end else if (bus.out_ready)
      r_valid <= 1'b0;
endmodule

// File: tb/tb_rr_mux_reg.sv
// tb_rr_mux_reg: scoreboard bench for rr_mux_reg with directed scenarios and random traffic
module tb_rr_mux_reg;
  localparam int WIDTH = 32;
  localparam int NCH = 4;
  localparam int CHW = 2;
  typedef struct { logic [WIDTH-1:0] d; int ch; } item_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rr_mux_reg_if #(.WIDTH(WIDTH), .NCH(NCH), .CHW(CHW)) bus();
  rr_mux_reg #(.WIDTH(WIDTH), .NCH(NCH), .CHW(CHW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int errors = 0;
  int checks = 0;
  item_t exp_q[$];
  int m_ptr = 0;
  bit m_full = 0;
  logic [NCH-1:0] ch_val = '0;
  logic [WIDTH-1:0] ch_data[NCH];
  int last_win;
  logic [NCH-1:0] last_rdy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic offer(input int k, input logic [WIDTH-1:0] d);
    ch_val[k] = 1'b1;
    ch_data[k] = d;
  endtask

  // one clock: drive at negedge, check ready against the model, advance the model
  task automatic step(input logic r, input logic ordy);
    int win;
    bit load;
    @(negedge clk);
    rst = r;
    bus.out_ready = ordy;
    bus.in_valid = ch_val;
    for (int k = 0; k < NCH; k++) bus.in_data[k*WIDTH +: WIDTH] = ch_data[k];
    #2;
    last_rdy = bus.in_ready;
    last_win = -1;
    for (int k = 0; k < NCH; k++) if (last_rdy[k]) last_win = k;
    if (r) begin
      check("rst_in_ready", {60'd0, bus.in_ready}, 64'd0);
      exp_q.delete();
      m_full = 0;
      m_ptr = 0;
    end else begin
      win = -1;
      load = (!m_full || ordy) && (ch_val != '0);
      if (load)
        for (int i = 0; i < NCH; i++)
          if (win < 0 && ch_val[(m_ptr + i) % NCH]) win = (m_ptr + i) % NCH;
      check("ptr", {62'd0, dut.r_ptr}, 64'(m_ptr));
      check("in_ready", {60'd0, bus.in_ready}, load ? 64'(1) << win : 64'd0);
      if (load) begin
        exp_q.push_back('{ch_data[win], win});
        m_ptr = (win + 1) % NCH;
        m_full = 1;
        ch_val[win] = 1'b0;
      end else if (ordy) m_full = 0;
    end
  endtask

  // monitor: presence of a word must match the scoreboard; every pop is compared
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        check("out_valid", {63'd0, bus.out_valid}, {63'd0, exp_q.size() != 0});
        if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
          it = exp_q.pop_front();
          check("out_data", {32'd0, bus.out_data}, {32'd0, it.d});
          check("out_ch", {62'd0, bus.out_ch}, 64'(it.ch));
        end
      end
    end
  end

  initial begin
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < NCH; k++) ch_data[k] = '0;
    // reset with every channel offering
    for (int k = 0; k < NCH; k++) offer(k, 32'h1000 + k);
    step(1, 1);
    step(1, 1);
    check("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_data", {32'd0, bus.out_data}, 64'd0);
    check("rst_ch", {62'd0, bus.out_ch}, 64'd0);
    ch_val = '0;
    // single channel
    offer(2, 32'hA5A5A5A5);
    step(0, 1);
    check("single_rdy", {60'd0, last_rdy}, 64'b0100);
    step(0, 1);
    check("single_data", {32'd0, bus.out_data}, 64'hA5A5A5A5);
    check("single_ptr", {62'd0, dut.r_ptr}, 64'd3);
    // round-robin with all channels continuously valid
    step(1, 1);
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NCH; k++) offer(k, 32'h11111111 * (k + 1));
      step(0, 1);
      check("rr_grant", 64'(last_win), 64'(i % NCH));
    end
    ch_val = '0;
    // backpressure
    step(1, 1);
    offer(0, 32'hC0C0C0C0);
    offer(1, 32'hC1C1C1C1);
    step(0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      check("bp_rdy", {60'd0, last_rdy}, 64'd0);
      check("bp_hold", {32'd0, bus.out_data}, 64'hC0C0C0C0);
    end
    step(0, 1);
    check("bp_grant", 64'(last_win), 64'd1);
    step(0, 1);
    check("bp_ch", {62'd0, bus.out_ch}, 64'd1);
    // wrap and skip
    step(1, 1);
    offer(2, 32'h22222222);
    step(0, 1);
    offer(1, 32'h01010101);
    offer(3, 32'h03030303);
    step(0, 1);
    check("wrap_first", 64'(last_win), 64'd3);
    step(0, 1);
    check("wrap_second", 64'(last_win), 64'd1);
    step(0, 1);
    check("wrap_ptr", {62'd0, dut.r_ptr}, 64'd2);
    // drain then mid-operation reset
    offer(0, 32'h12345678);
    step(0, 1);
    step(0, 1);
    step(0, 1);
    check("drain_valid", {63'd0, bus.out_valid}, 64'd0);
    offer(0, 32'hDEADBEEF);
    step(0, 0);
    step(1, 0);
    step(0, 0);
    check("mrst_valid", {63'd0, bus.out_valid}, 64'd0);
    check("mrst_data", {32'd0, bus.out_data}, 64'd0);
    // random traffic; producers hold their word until granted
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NCH; k++)
        if (!ch_val[k] && $urandom_range(0, 2) == 0) offer(k, $urandom);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7);
    end
    ch_val = '0;
    for (int c = 0; c < 4; c++) step(0, 1);
    check("final_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
